// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift sequencer that drives a single-step shifter.
//   A command (op, amt, din) is loaded into an accumulator. The shifter is
//   then stepped once per clock, and each step's dout/c is fed back into the
//   accumulator. The final value and carry are held for downstream logic.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, op, amt, din   command strobe, shifter sel code, step count, operand
//   sh_din, sh_sel        to shifter (accumulator, latched op while shifting)
//   sh_dout, sh_c         from shifter
//   busy, done            shifting / one-cycle result strobe
//   dout, c, z, n         result, last carry, optional zero/negative flags
// Build option: define SHIFT_FLAGS_EN to register z/n on entry to DONE;
//   otherwise z and n are tied to 0.
module shift_seq #(
  parameter int bw = 8,
  parameter int cw = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [cw-1:0] amt,
  input  logic [bw-1:0] din,
  output logic [bw-1:0] sh_din,
  output logic [2:0]    sh_sel,
  input  logic [bw-1:0] sh_dout,
  input  logic          sh_c,
  output logic          busy,
  output logic          done,
  output logic [bw-1:0] dout,
  output logic          c,
  output logic          z,
  output logic          n
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [bw-1:0]   acc_q, acc_d;
  logic [cw-1:0]   cnt_q, cnt_d;
  logic [2:0]      opr_q, opr_d;
  logic            c_q, c_d;
  logic            accept, passthru;

  // A start is only honoured outside SHIFT; DONE accepts for back-to-back use.
  assign accept   = start && (state_q != SHIFT);
  // Moves (000/110/111) and zero-step commands skip the shifter entirely.
  assign passthru = (amt == '0) || (op == 3'b000) || (op == 3'b110) || (op == 3'b111);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    c_d     = c_q;
    case (state_q)
      SHIFT: begin
        acc_d   = sh_dout;
        c_d     = sh_c;
        cnt_d   = cnt_q - cw'(1);
        state_d = (cnt_q == cw'(1)) ? DONE : SHIFT;
      end
      default: begin
        if (accept) begin
          acc_d   = din;
          cnt_d   = amt;
          opr_d   = op;
          c_d     = 1'b0;
          state_d = passthru ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      opr_q   <= 3'b000;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
      c_q     <= c_d;
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic z_q, n_q;
  logic flag_ld;

  // Entry into DONE: either the last shift step or an accepted pass-through
  // (the latter also covers DONE -> DONE on a back-to-back command).
  assign flag_ld = (state_d == DONE) && ((state_q == SHIFT) || accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (flag_ld) begin
      z_q <= (acc_d == '0);
      n_q <= acc_d[bw-1];
    end
  end

  assign z = z_q;
  assign n = n_q;
`else
  assign z = 1'b0;
  assign n = 1'b0;
`endif

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign sh_din = acc_q;
  assign sh_sel = busy ? opr_q : 3'b000;
  assign dout   = acc_q;
  assign c      = c_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;
  localparam int BW = 8;
  localparam int CW = 3;
`ifdef SHIFT_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [CW-1:0] amt;
  logic [BW-1:0] din;
  logic [BW-1:0] sh_din, sh_dout, dout;
  logic [2:0]    sh_sel;
  logic          sh_c, busy, done, c, z, n;

  shift_seq #(.bw(BW), .cw(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt), .din(din),
    .sh_din(sh_din), .sh_sel(sh_sel), .sh_dout(sh_dout), .sh_c(sh_c),
    .busy(busy), .done(done), .dout(dout), .c(c), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  // Reference single-step shifter.
  always_comb begin
    sh_dout = sh_din;
    sh_c    = 1'b0;
    case (sh_sel)
      3'b001: begin sh_dout = {sh_din[7], sh_din[7:1]}; sh_c = sh_din[0]; end
      3'b010: begin sh_dout = {1'b0, sh_din[7:1]};      sh_c = sh_din[0]; end
      3'b011: begin sh_dout = {sh_din[6:0], 1'b0};      sh_c = sh_din[7]; end
      3'b100: begin sh_dout = {sh_din[0], sh_din[7:1]}; sh_c = sh_din[0]; end
      3'b101: begin sh_dout = {sh_din[6:0], sh_din[7]}; sh_c = sh_din[7]; end
      default: ;
    endcase
  end

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic       c, z, n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_dout"}, 32'(dout), 32'(e.d));
        chk({e.nm, "_c"},    32'(c),    32'(e.c));
        chk({e.nm, "_z"},    32'(z),    32'(e.z));
        chk({e.nm, "_n"},    32'(n),    32'(e.n));
      end
    end
  end

  // Drive a command for the upcoming edge; caller positions at a negedge.
  task automatic send(input string nm, input logic [2:0] o, input logic [2:0] a,
                      input logic [7:0] d, input logic [7:0] ed, input logic ec,
                      input logic ez, input logic en, input bit push);
    exp_t e;
    op = o; amt = a; din = d; start = 1'b1;
    if (push) begin
      e.nm = nm; e.d = ed; e.c = ec; e.z = ez & FL; e.n = en & FL;
      q.push_back(e);
    end
  endtask

  // Waits for done, checking latency and busy-cycle count. If poke>0, a
  // start with unrelated data is issued at that cycle (should be ignored).
  task automatic wait_done(input string nm, input int lat, input int bcy, input int poke);
    int cyc = 0;
    int bc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) begin op = 3'b000; amt = '0; din = 8'hFF; end
      if (busy) bc++;
    end while (!done && cyc < 40);
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    chk({nm, "_busycyc"}, 32'(bc), 32'(bcy));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; amt = '0; din = '0;
    #7;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_c",    32'(c),    0);
    chk("rst_zn",   32'({z, n}), 0);
    chk("rst_sel",  32'(sh_sel), 0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); send("lsl1", 3'b011, 3'd1, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0, 1);
    wait_done("lsl1", 2, 1, 0);

    @(negedge clk); send("asr3", 3'b001, 3'd3, 8'h80, 8'hF0, 1'b0, 1'b0, 1'b1, 1);
    wait_done("asr3", 4, 3, 0);

    @(negedge clk); send("rsl7", 3'b101, 3'd7, 8'h81, 8'hC0, 1'b0, 1'b0, 1'b1, 1);
    wait_done("rsl7", 8, 7, 0);
    repeat (3) @(negedge clk);
    chk("hold_dout", 32'(dout), 32'h00C0);
    chk("hold_c",    32'(c),    0);

    @(negedge clk); send("lsr0", 3'b010, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
    wait_done("lsr0", 1, 0, 0);
    @(negedge clk); send("op7", 3'b111, 3'd5, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
    wait_done("op7", 1, 0, 0);
    @(negedge clk); send("mvb", 3'b000, 3'd3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    wait_done("mvb", 1, 0, 0);

    // Back-to-back chain: each new command is issued in the done cycle.
    @(negedge clk); send("lsr1", 3'b010, 3'd1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    wait_done("lsr1", 2, 1, 0);
    send("b2b_rsr", 3'b100, 3'd1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1);
    wait_done("b2b_rsr", 2, 1, 0);
    send("b2b_mv", 3'b110, 3'd2, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1);
    wait_done("b2b_mv", 1, 0, 0);

    // Start during SHIFT must not disturb the running command.
    @(negedge clk); send("ign", 3'b011, 3'd4, 8'h03, 8'h30, 1'b0, 1'b0, 1'b0, 1);
    wait_done("ign", 5, 4, 2);

    // Asynchronous reset mid-shift, observed between clock edges.
    @(negedge clk); send("abort", 3'b011, 3'd7, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_dout", 32'(dout), 0);
    chk("abort_c",    32'(c),    0);
    chk("abort_zn",   32'({z, n}), 0);
    chk("abort_sel",  32'(sh_sel), 0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); send("post", 3'b011, 3'd1, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0, 1);
    wait_done("post", 2, 1, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
